// File: rtl/serial_pair_comparator_if.sv
// Request/result bundle for serial_pair_comparator.
// Handshake: a compare is accepted on any rising edge where start=1 and
// busy=0 (including the edge that ends the done cycle). done pulses for one
// cycle when eq/gt/lt become valid; valid stays high until the next accept.
// dbg_run and dbg_flags expose the FSM state and running e/g/l flags.
interface serial_pair_comparator_if #(
  parameter int N = 4
);
  localparam int W = 2 * N;

  logic         start;
  logic         signed_mode;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic         valid;
  logic         eq;
  logic         gt;
  logic         lt;
  logic         dbg_run;
  logic [2:0]   dbg_flags;

  modport master (
    output start, signed_mode, x, y,
    input  busy, done, valid, eq, gt, lt, dbg_run, dbg_flags
  );

  modport slave (
    input  start, signed_mode, x, y,
    output busy, done, valid, eq, gt, lt, dbg_run, dbg_flags
  );
endinterface

// File: rtl/serial_pair_comparator.sv
// Bit-serial 2N-bit magnitude comparator: one 2-bit pair per clock, MSB pair
// first, with running equal/greater/less flags. Signed operands are handled
// by swapping gt/lt at the end when the sign bits differ.
module serial_pair_comparator #(
  parameter int N = 4
) (
  input logic                     clk,
  input logic                     reset,
  serial_pair_comparator_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   xr;
  logic [W-1:0]   yr;
  logic           sr;
  logic [KW-1:0]  k;
  logic           e;
  logic           g;
  logic           l;
  logic           accept;
  logic           finish;
  logic           last;
  logic [1:0]     xp;
  logic [1:0]     yp;
  logic           e_nx;
  logic           g_nx;
  logic           l_nx;
  logic           swap;
  logic           done_r;
  logic           valid_r;
  logic           eq_r;
  logic           gt_r;
  logic           lt_r;

  // Current pair under examination and the flag update it produces.
  assign last = (k == '0);
  assign xp   = xr[{k, 1'b0} +: 2];
  assign yp   = yr[{k, 1'b0} +: 2];
  assign g_nx = g | (e & (xp > yp));
  assign l_nx = l | (e & (xp < yp));
  assign e_nx = e & (xp == yp);
  // Differing sign bits in two's complement invert the unsigned ordering.
  assign swap = sr & (xr[W-1] ^ yr[W-1]);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; accept and finish mark the two transition edges.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and pair counter; counter holds at 0 on the last pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xr <= '0;
      yr <= '0;
      sr <= 1'b0;
      k  <= '0;
    end else if (accept) begin
      xr <= bus.x;
      yr <= bus.y;
      sr <= bus.signed_mode;
      k  <= KW'(N - 1);
    end else if (state == RUN && !last) begin
      k <= k - 1'b1;
    end
  end

  // Running flags: preset to "equal so far", then refined pair by pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e <= 1'b0;
      g <= 1'b0;
      l <= 1'b0;
    end else if (accept) begin
      e <= 1'b1;
      g <= 1'b0;
      l <= 1'b0;
    end else if (state == RUN) begin
      e <= e_nx;
      g <= g_nx;
      l <= l_nx;
    end
  end

  // Result registers: loaded with corrected flags as the last pair retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      eq_r    <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
    end else begin
      done_r <= finish;
      if (finish) begin
        valid_r <= 1'b1;
        eq_r    <= e_nx;
        gt_r    <= swap ? l_nx : g_nx;
        lt_r    <= swap ? g_nx : l_nx;
      end else if (accept) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = done_r;
  assign bus.valid     = valid_r;
  assign bus.eq        = eq_r;
  assign bus.gt        = gt_r;
  assign bus.lt        = lt_r;
  assign bus.dbg_run   = (state == RUN);
  assign bus.dbg_flags = {e, g, l};
endmodule

// File: tb/tb_serial_pair_comparator.sv
// Bench for serial_pair_comparator (N=4): directed scenarios plus a random
// back-to-back sweep scored against an arithmetic reference model.
module tb_serial_pair_comparator;
  localparam int N     = 4;
  localparam int W     = 2 * N;
  localparam int NRAND = 10000;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  logic inv_on;
  logic [2:0] exp_q[$];

  serial_pair_comparator_if #(.N(N)) bus ();

  serial_pair_comparator #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer ordering of the operands, returns {eq,gt,lt}.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (a == b)             return 3'b100;
    if (s ? (sa > sb) : (a > b)) return 3'b010;
    return 3'b001;
  endfunction

  // Running flags and held result must each be one-hot.
  always @(negedge clk) begin
    if (inv_on && !reset) begin
      if (bus.busy) begin
        n_total++;
        if (!$onehot(bus.dbg_flags))
          $display("FAIL flags_onehot: got %b required one-hot", bus.dbg_flags);
        else n_pass++;
      end
      if (bus.valid) begin
        n_total++;
        if (!$onehot({bus.eq, bus.gt, bus.lt}))
          $display("FAIL result_onehot: got %b required one-hot", {bus.eq, bus.gt, bus.lt});
        else n_pass++;
      end
    end
  end

  // Driver: called at a negedge; returns at the negedge one cycle after accept,
  // with operands scrambled to show they were captured.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.x           = a;
    bus.y           = b;
    bus.signed_mode = s;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.x           = W'($urandom());
    bus.y           = W'($urandom());
    bus.signed_mode = 1'($urandom());
  endtask

  // Driver: waits (bounded) for done; lat counts cycles since accept.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.busy, bus.done, bus.valid, bus.eq, bus.gt, bus.lt} !== 6'b0)
      $display("FAIL reset_outputs: got %b required 000000",
               {bus.busy, bus.done, bus.valid, bus.eq, bus.gt, bus.lt});
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int busy_ok;
    busy_ok = 1;
    launch(8'hA5, 8'hA5, 1'b0);
    for (int c = 1; c <= N; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_ok = 0;
      @(negedge clk);
    end
    n_total++;
    if (busy_ok != 1) $display("FAIL basic_busy_window: got %0d required 1", busy_ok);
    else n_pass++;
    n_total++;
    if ({bus.busy, bus.done, bus.valid} !== 3'b011)
      $display("FAIL basic_done_cycle: got %b required 011", {bus.busy, bus.done, bus.valid});
    else n_pass++;
    n_total++;
    if ({bus.eq, bus.gt, bus.lt} !== 3'b100)
      $display("FAIL basic_result: got %b required 100", {bus.eq, bus.gt, bus.lt});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.done, bus.valid, bus.eq} !== 3'b011)
      $display("FAIL basic_hold: got %b required 011", {bus.done, bus.valid, bus.eq});
    else n_pass++;
  endtask

  task automatic test_signed();
    int lat;
    logic [W-1:0] xs[3] = '{8'h80, 8'h80, 8'hFE};
    logic [W-1:0] ys[3] = '{8'h7F, 8'h7F, 8'hFF};
    logic         ss[3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]   ex[3] = '{3'b010, 3'b001, 3'b001};
    for (int i = 0; i < 3; i++) begin
      launch(xs[i], ys[i], ss[i]);
      wait_done(1, lat);
      n_total++;
      if ({bus.eq, bus.gt, bus.lt} !== ex[i] || lat != N + 1)
        $display("FAIL signed_case%0d: got %b lat %0d required %b lat %0d",
                 i, {bus.eq, bus.gt, bus.lt}, lat, ex[i], N + 1);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_decision_points();
    int lat;
    // Decided on the last pair: flags stay "equal" until then.
    launch(8'h01, 8'h02, 1'b0);
    repeat (N - 1) @(negedge clk);
    n_total++;
    if (bus.dbg_flags !== 3'b100)
      $display("FAIL late_flags: got %b required 100", bus.dbg_flags);
    else n_pass++;
    wait_done(N, lat);
    n_total++;
    if ({bus.eq, bus.gt, bus.lt} !== 3'b001 || lat != N + 1)
      $display("FAIL late_result: got %b lat %0d required 001 lat %0d",
               {bus.eq, bus.gt, bus.lt}, lat, N + 1);
    else n_pass++;
    @(negedge clk);
    // Decided on the first pair and held.
    launch(8'hC0, 8'h3F, 1'b0);
    @(negedge clk);
    n_total++;
    if (bus.dbg_flags !== 3'b010)
      $display("FAIL early_flags: got %b required 010", bus.dbg_flags);
    else n_pass++;
    wait_done(2, lat);
    n_total++;
    if ({bus.eq, bus.gt, bus.lt} !== 3'b010 || lat != N + 1)
      $display("FAIL early_result: got %b lat %0d required 010 lat %0d",
               {bus.eq, bus.gt, bus.lt}, lat, N + 1);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int lat;
    int extra_done;
    launch(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    bus.x = 8'hFF; bus.y = 8'h00; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, lat);
    n_total++;
    if ({bus.eq, bus.gt, bus.lt} !== 3'b001 || lat != N + 1)
      $display("FAIL busy_ignore: got %b lat %0d required 001 lat %0d",
               {bus.eq, bus.gt, bus.lt}, lat, N + 1);
    else n_pass++;
    extra_done = 0;
    for (int c = 0; c < N + 2; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra_done++;
    end
    n_total++;
    if (extra_done != 0 || bus.valid !== 1'b1)
      $display("FAIL busy_ignore_after: got %0d stray cycles valid %b required 0 valid 1",
               extra_done, bus.valid);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int lat;
    int stray;
    launch(8'h33, 8'h22, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if ({bus.busy, bus.done, bus.valid, bus.eq, bus.gt, bus.lt} !== 6'b0)
      $display("FAIL midrun_reset: got %b required 000000",
               {bus.busy, bus.done, bus.valid, bus.eq, bus.gt, bus.lt});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < N + 2; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    n_total++;
    if (stray != 0) $display("FAIL midrun_no_done: got %0d stray cycles required 0", stray);
    else n_pass++;
    launch(8'h33, 8'h22, 1'b0);
    wait_done(1, lat);
    n_total++;
    if ({bus.eq, bus.gt, bus.lt} !== 3'b010 || lat != N + 1)
      $display("FAIL midrun_restart: got %b lat %0d required 010 lat %0d",
               {bus.eq, bus.gt, bus.lt}, lat, N + 1);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(8'h05, 8'h04, 1'b0);
    wait_done(1, lat);
    launch(8'hF0, 8'h0F, 1'b1);
    n_total++;
    if ({bus.done, bus.valid, bus.busy} !== 3'b001)
      $display("FAIL b2b_accept_cycle: got %b required 001", {bus.done, bus.valid, bus.busy});
    else n_pass++;
    wait_done(1, lat);
    n_total++;
    if ({bus.eq, bus.gt, bus.lt} !== 3'b001 || lat != N + 1)
      $display("FAIL b2b_second: got %b lat %0d required 001 lat %0d",
               {bus.eq, bus.gt, bus.lt}, lat, N + 1);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int         lat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       s;
    logic [2:0] exp;
    logic [2:0] got;
    a = W'($urandom()); b = W'($urandom()); s = 1'($urandom());
    exp_q.push_back(ref_cmp(a, b, s));
    launch(a, b, s);
    for (int i = 0; i < NRAND; i++) begin
      wait_done(1, lat);
      got = {bus.eq, bus.gt, bus.lt};
      exp = exp_q.pop_front();
      n_total++;
      if (got !== exp || lat != N + 1)
        $display("FAIL random_%0d: got %b lat %0d required %b lat %0d", i, got, lat, exp, N + 1);
      else n_pass++;
      if (i < NRAND - 1) begin
        a = W'($urandom());
        b = ($urandom_range(0, 7) == 0) ? a : W'($urandom());
        s = 1'($urandom_range(0, 1));
        exp_q.push_back(ref_cmp(a, b, s));
        launch(a, b, s);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_pass          = 0;
    n_total         = 0;
    inv_on          = 1'b0;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.x           = '0;
    bus.y           = '0;
    @(negedge clk);
    test_reset();
    inv_on = 1'b1;
    test_basic();
    test_signed();
    test_decision_points();
    test_busy_ignore();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    inv_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/serial_pair_comparator.md
Name: serial_pair_comparator

Overview:
- Sequential 2N-bit magnitude comparator that examines one bit pair per clock, most-significant pair first.
- Holds the running equal/greater/less state in registers, so the whole width uses one pair-compare stage instead of N chained slices.
- Supports unsigned and two's-complement operands.
- Results go to board-level display/LED logic or to other FSMs through a start/done handshake.

Parameters:
- N, 4: number of bit pairs. Operand width W = 2N. Legal values are N >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a compare. Accepted only while busy=0.
- signed_mode  in  1  1 = operands are two's complement. Sampled on accept.
- x  in  W  operand X. Sampled on accept.
- y  in  W  operand Y. Sampled on accept.
- busy  out  1  high while a compare is in progress.
- done  out  1  single-cycle pulse when a result becomes valid.
- valid  out  1  high from done until the next accepted start.
- eq  out  1  X == Y. Held while valid.
- gt  out  1  X > Y. Held while valid.
- lt  out  1  X < Y. Held while valid.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; busy, done, valid, eq, gt and lt all = 0.
  - Operand registers and pair counter cleared.
  - An in-flight compare is discarded and produces no done pulse.
- States: IDLE and RUN.
- IDLE:
  - start=1 captures x, y and signed_mode into internal registers.
  - Running flags preset: e=1, g=0, l=0. Pair index k = N-1.
  - Next state RUN. valid drops to 0 in the accept cycle.
- RUN (one pair per cycle), comparing xp = Xr[2k+1:2k] with yp = Yr[2k+1:2k] as 2-bit unsigned values:
  - g <= g | (e & (xp > yp))
  - l <= l | (e & (xp < yp))
  - e <= e & (xp == yp)
  - k decrements. The cycle that processes k = 0 returns the FSM to IDLE.
- Invariant: exactly one of e, g, l is 1 after every RUN cycle. The bench asserts this.
- Sign correction, applied once when the final pair retires:
  - If signed_mode_r=1 and Xr[W-1] != Yr[W-1], the final g and l are swapped. eq is unaffected.
- Output registers on the first IDLE cycle after RUN:
  - eq/gt/lt take the corrected flags.
  - done = 1 for exactly one cycle; valid = 1.
- Latency: start accepted at edge t gives done high in the cycle following edge t+N. Latency is fixed at N+1 cycles; there is no early exit even when the result is decided early.
- busy = 1 exactly while state = RUN, i.e. N cycles per compare.
- Handshake rules:
  - start while busy=1 is ignored: no effect on operands, counter or outputs.
  - start in the done cycle is accepted. This allows back-to-back compares at a throughput of one per N+1 cycles.
  - In the accept cycle, done drops and valid drops; eq/gt/lt keep their old values but are meaningless while valid=0.
  - x, y and signed_mode may change freely after accept.
- Widths: counter width is max(1, $clog2(N)). The counter must not wrap below 0. For N=1, RUN lasts a single cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- N=4, unsigned: x=8'hA5, y=8'hA5, start at cycle 0 -> busy on cycles 1-4, done pulse in cycle 5, eq=1 gt=0 lt=0, valid held until next start.
- N=4: x=8'h80, y=8'h7F
  - signed_mode=0 -> gt=1.
  - signed_mode=1 -> lt=1.
  - x=8'hFE, y=8'hFF, signed_mode=1 -> lt=1 (signs equal, no swap).
- N=4, unsigned: x=8'h01, y=8'h02 -> lt=1, decided only on the last pair. x=8'hC0, y=8'h3F -> gt=1, decided on the first pair and held through the remaining pairs.
- Pulse start during busy with different operands -> ignored; result matches the first operands; latency unchanged.
- Assert reset in the 2nd RUN cycle -> all outputs 0 immediately, no done pulse. A start after reset release completes normally.
- Back-to-back: assert start in the done cycle with new operands -> accepted; second done arrives exactly N+1 cycles later. Finish with a random sweep of 10k signed/unsigned pairs checked against a reference model, with the one-hot flag invariant asserted throughout.
